// File: rtl/dcu_pkg.sv
// Shared definitions for the data conversion units: serializer FSM state encoding.
package dcu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAITR = 2'b01,
    READY = 2'b10
  } ser_state_t;

endpackage

// File: rtl/ser_word_reg.sv
// Word holding register, bit index and bit select; load is single-cycle and wins over advance.
// Index returns to 0 after the last bit, so non-power-of-2 widths never expose unused indices.
module ser_word_reg #(
  parameter int WORD_W    = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              adv,
  input  logic [WORD_W-1:0] word_in,
  output logic              bit_out,
  output logic              word_last
);

  localparam int               IDX_W    = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0] word_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (load) begin
      word_q <= word_in;
      idx_q  <= '0;
    end else if (adv) begin
      idx_q <= word_last ? '0 : idx_q + 1'b1;
    end
  end

  assign word_last = (idx_q == LAST_IDX);
  assign sel       = (MSB_FIRST != 0) ? (LAST_IDX - idx_q) : idx_q;
  assign bit_out   = word_q[sel];

endmodule

// File: rtl/word_serializer.sv
// Pops words from a first-word-fall-through FIFO and streams them one bit per transfer; first bit 2 cycles after enb.
// bit_ready=0 stalls with bit_out held; consecutive words reload on the last transfer with no bubble.
module word_serializer
  import dcu_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enb,
  input  logic              fifo_rempty,
  input  logic [WORD_W-1:0] fifo_rdata,
  output logic              fifo_rinc,
  input  logic              bit_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              word_last,
  output logic              underrun
);

  ser_state_t state_q, state_d;
  logic       xfer;
  logic       last_xfer;

  assign xfer      = (state_q == READY) && bit_ready;
  assign last_xfer = xfer && word_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enb) state_d = WAITR;
      end
      WAITR: begin
        if (!enb)             state_d = IDLE;
        else if (!fifo_rempty) state_d = READY;
      end
      READY: begin
        // A word in flight always finishes; enb is only sampled at its last bit.
        if (last_xfer) begin
          if (!enb)             state_d = IDLE;
          else if (fifo_rempty) state_d = WAITR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_rinc = 1'b0;
    bit_valid = 1'b0;
    case (state_q)
      WAITR: fifo_rinc = enb && !fifo_rempty;
      READY: begin
        bit_valid = 1'b1;
        fifo_rinc = last_xfer && enb && !fifo_rempty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               underrun <= 1'b0;
    else if (last_xfer && enb && fifo_rempty) underrun <= 1'b1;
    else if (state_q == IDLE && !enb)       underrun <= 1'b0;
  end

  ser_word_reg #(
    .WORD_W    (WORD_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_word_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (fifo_rinc),
    .adv       (xfer),
    .word_in   (fifo_rdata),
    .bit_out   (bit_out),
    .word_last (word_last)
  );

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench: 8-bit LSB-first, 8-bit MSB-first and 5-bit serializers behind FIFO models,
// expected {last,bit} pairs queued per pushed word and checked on every transfer.
module tb_word_serializer;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       enb       = 1'b0;
  logic       bit_ready = 1'b0;
  logic       rempty    = 1'b1;
  logic [7:0] rdata     = 8'h00;
  logic       c_rempty  = 1'b1;
  logic [4:0] c_rdata   = 5'h00;

  logic a_rinc, a_bout, a_bvalid, a_wlast, a_und;
  logic b_rinc, b_bout, b_bvalid, b_wlast, b_und;
  logic c_rinc, c_bout, c_bvalid, c_wlast, c_und;

  logic [7:0] fq[$];
  logic [4:0] fq_c[$];
  logic [1:0] exp_a[$];
  logic [1:0] exp_b[$];
  logic [1:0] exp_c[$];
  logic [7:0] pop_w;
  logic [4:0] pop_wc;
  logic [1:0] ea, eb, ec;

  int checks   = 0;
  int failures = 0;
  int xfer_a   = 0;
  int xfer_c   = 0;
  int rinc_a   = 0;
  int rinc_b   = 0;
  int drops    = 0;
  logic       prev_valid   = 1'b0;
  logic       hold_pending = 1'b0;
  logic [1:0] held         = 2'b00;

  always #5 clk = ~clk;

  word_serializer #(.WORD_W(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .enb(enb), .fifo_rempty(rempty), .fifo_rdata(rdata),
    .fifo_rinc(a_rinc), .bit_ready(bit_ready), .bit_out(a_bout), .bit_valid(a_bvalid),
    .word_last(a_wlast), .underrun(a_und)
  );

  word_serializer #(.WORD_W(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .enb(enb), .fifo_rempty(rempty), .fifo_rdata(rdata),
    .fifo_rinc(b_rinc), .bit_ready(bit_ready), .bit_out(b_bout), .bit_valid(b_bvalid),
    .word_last(b_wlast), .underrun(b_und)
  );

  word_serializer #(.WORD_W(5), .MSB_FIRST(0)) u_w5 (
    .clk(clk), .rst(rst), .enb(enb), .fifo_rempty(c_rempty), .fifo_rdata(c_rdata),
    .fifo_rinc(c_rinc), .bit_ready(bit_ready), .bit_out(c_bout), .bit_valid(c_bvalid),
    .word_last(c_wlast), .underrun(c_und)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    fq.push_back(w);
    for (int i = 0; i < 8; i++) begin
      exp_a.push_back({i == 7, w[i]});
      exp_b.push_back({i == 7, w[7-i]});
    end
  endtask

  task automatic push_c(input logic [4:0] w);
    fq_c.push_back(w);
    for (int i = 0; i < 5; i++) exp_c.push_back({i == 4, w[i]});
  endtask

  task automatic wait_ab(input string tag);
    int n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 16'(exp_a.size() + exp_b.size()), 16'd0);
  endtask

  task automatic wait_c(input string tag);
    int n = 0;
    while (exp_c.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 16'(exp_c.size()), 16'd0);
  endtask

  // FWFT FIFO models: pop on rinc, head and empty become visible at the clock edge.
  always @(posedge clk) begin
    if (a_rinc && fq.size() != 0) pop_w = fq.pop_front();
    if (c_rinc && fq_c.size() != 0) pop_wc = fq_c.pop_front();
    rempty   <= (fq.size() == 0);
    rdata    <= (fq.size() != 0) ? fq[0] : 8'h00;
    c_rempty <= (fq_c.size() == 0);
    c_rdata  <= (fq_c.size() != 0) ? fq_c[0] : 5'h00;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (a_rinc) begin
        rinc_a++;
        chk("a_rinc_while_empty", 16'(rempty), 16'd0);
      end
      if (b_rinc) rinc_b++;
      if (c_rinc) chk("c_rinc_while_empty", 16'(c_rempty), 16'd0);
      if (hold_pending && a_bvalid) chk("a_hold_on_stall", 16'({a_wlast, a_bout}), 16'(held));
      hold_pending = a_bvalid && !bit_ready;
      held         = {a_wlast, a_bout};
      if (prev_valid && !a_bvalid && exp_a.size() != 0) drops++;
      prev_valid = a_bvalid;
      if (a_bvalid && bit_ready) begin
        xfer_a++;
        chk("a_bit_expected", 16'(exp_a.size() != 0), 16'd1);
        if (exp_a.size() != 0) begin
          ea = exp_a.pop_front();
          chk("a_bit", 16'(a_bout), 16'(ea[0]));
          chk("a_last", 16'(a_wlast), 16'(ea[1]));
        end
      end
      if (b_bvalid && bit_ready) begin
        chk("b_bit_expected", 16'(exp_b.size() != 0), 16'd1);
        if (exp_b.size() != 0) begin
          eb = exp_b.pop_front();
          chk("b_bit", 16'(b_bout), 16'(eb[0]));
          chk("b_last", 16'(b_wlast), 16'(eb[1]));
        end
      end
      if (c_bvalid && bit_ready) begin
        xfer_c++;
        chk("c_bit_expected", 16'(exp_c.size() != 0), 16'd1);
        if (exp_c.size() != 0) begin
          ec = exp_c.pop_front();
          chk("c_bit", 16'(c_bout), 16'(ec[0]));
          chk("c_last", 16'(c_wlast), 16'(ec[1]));
        end
      end
    end
  end

  initial begin
    int base_x, base_r, base_rb, base_d, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_bvalid", 16'(a_bvalid), 16'd0);
    chk("rst_a_bout", 16'(a_bout), 16'd0);
    chk("rst_a_wlast", 16'(a_wlast), 16'd0);
    chk("rst_a_underrun", 16'(a_und), 16'd0);
    chk("rst_a_rinc", 16'(a_rinc), 16'd0);
    chk("rst_c_bvalid", 16'(c_bvalid), 16'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single word, then the FIFO runs dry with enb held: underrun, refill, clear.
    base_x = xfer_a; base_r = rinc_a;
    enb = 1'b1; bit_ready = 1'b1;
    push_word(8'hA5);
    wait_ab("t1_word_done");
    repeat (2) @(posedge clk);
    #1;
    chk("t1_xfers", 16'(xfer_a - base_x), 16'd8);
    chk("t1_pops", 16'(rinc_a - base_r), 16'd1);
    chk("t1_underrun_a", 16'(a_und), 16'd1);
    chk("t1_underrun_b", 16'(b_und), 16'd1);
    chk("t1_waitr_bvalid", 16'(a_bvalid), 16'd0);
    push_word(8'hFF);
    n = 0;
    while (!a_bvalid && n < 20) begin @(posedge clk); #1; n++; end
    chk("t1_resumed", 16'(a_bvalid), 16'd1);
    chk("t1_underrun_sticky", 16'(a_und), 16'd1);
    wait_ab("t1_refill_done");
    enb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t1_underrun_cleared_a", 16'(a_und), 16'd0);
    chk("t1_underrun_cleared_b", 16'(b_und), 16'd0);

    // Back-to-back words: no bubble, exactly two pops.
    push_word(8'hA5);
    push_word(8'h3C);
    repeat (2) @(posedge clk);
    #1;
    base_x = xfer_a; base_r = rinc_a; base_rb = rinc_b; base_d = drops;
    enb = 1'b1;
    wait_ab("t2_done");
    chk("t2_xfers", 16'(xfer_a - base_x), 16'd16);
    chk("t2_drops", 16'(drops - base_d), 16'd0);
    chk("t2_pops_a", 16'(rinc_a - base_r), 16'd2);
    chk("t2_pops_b", 16'(rinc_b - base_rb), 16'd2);
    enb = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Toggling bit_ready with enb dropped mid-word: word completes in 16 cycles, no extra pop.
    push_word(8'hA5);
    push_word(8'h5A);
    repeat (2) @(posedge clk);
    #1;
    base_r = rinc_a;
    enb = 1'b1; bit_ready = 1'b1;
    n = 0;
    while (!a_bvalid && n < 20) begin @(posedge clk); #1; n++; end
    chk("t3_started", 16'(a_bvalid), 16'd1);
    enb = 1'b0;
    base_x = xfer_a;
    for (int i = 0; i < 16; i++) begin
      bit_ready = (i % 2 == 0);
      @(posedge clk); #1;
    end
    chk("t3_xfers_16cyc", 16'(xfer_a - base_x), 16'd8);
    chk("t3_sb_remaining", 16'(exp_a.size()), 16'd8);
    chk("t3_pops", 16'(rinc_a - base_r), 16'd1);
    chk("t3_fifo_left", 16'(fq.size()), 16'd1);
    chk("t3_idle_bvalid", 16'(a_bvalid), 16'd0);
    chk("t3_no_underrun", 16'(a_und), 16'd0);

    // Reset at bit 3 discards the word; restart reads the next FIFO word.
    push_word(8'h3C);
    repeat (2) @(posedge clk);
    #1;
    base_r = rinc_a; base_x = xfer_a;
    bit_ready = 1'b1; enb = 1'b1;
    n = 0;
    while ((xfer_a - base_x) < 3 && n < 40) begin @(posedge clk); #1; n++; end
    chk("t4_at_bit3", 16'(xfer_a - base_x), 16'd3);
    rst = 1'b1;
    #1;
    chk("t4_rst_bvalid", 16'(a_bvalid), 16'd0);
    chk("t4_rst_bout", 16'(a_bout), 16'd0);
    chk("t4_rst_wlast", 16'(a_wlast), 16'd0);
    chk("t4_rst_rinc", 16'(a_rinc), 16'd0);
    chk("t4_rst_b_bvalid", 16'(b_bvalid), 16'd0);
    while (exp_a.size() > 8) ea = exp_a.pop_front();
    while (exp_b.size() > 8) eb = exp_b.pop_front();
    @(posedge clk); #1;
    chk("t4_fifo_untouched", 16'(fq.size()), 16'd1);
    rst = 1'b0;
    wait_ab("t4_restart_done");
    chk("t4_pops", 16'(rinc_a - base_r), 16'd2);
    chk("t4_fifo_drained", 16'(fq.size()), 16'd0);
    enb = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Five-bit words: exactly five bits each, index restarts for the next word.
    base_x = xfer_c;
    enb = 1'b1; bit_ready = 1'b1;
    push_c(5'b10011);
    wait_c("t5_word1_done");
    repeat (3) @(posedge clk);
    #1;
    chk("t5_xfers", 16'(xfer_c - base_x), 16'd5);
    chk("t5_no_sixth_bit", 16'(c_bvalid), 16'd0);
    chk("t5_wlast_clear", 16'(c_wlast), 16'd0);
    chk("t5_underrun", 16'(c_und), 16'd1);
    push_c(5'b01101);
    wait_c("t5_word2_done");
    repeat (2) @(posedge clk);
    #1;
    chk("t5_xfers_total", 16'(xfer_c - base_x), 16'd10);
    enb = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
